// File: rtl/tcdm_bank_responder.sv
// Single-port TCDM slave bank: grants requests, performs byte-enabled writes, returns read data
// after a fixed latency through a valid/data shift pipe, and counts accepted traffic.
module tcdm_bank_responder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned NB_WORDS     = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    stall_i,
  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_valid_o,
  output logic [31:0]             nb_reads_o,
  output logic [31:0]             nb_writes_o,
  output logic                    err_o
);

  localparam int unsigned BeW   = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(BeW);
  localparam int unsigned IdxW  = $clog2(NB_WORDS);
  localparam int unsigned HiLsb = OffW + IdxW;
  localparam logic [31:0] DeadWord = 32'hDEAD_BEEF;

  logic                  accept, rd_accept, wr_accept;
  logic [IdxW-1:0]       word_idx;
  logic [ADDR_WIDTH-1:0] add_hi;
  logic                  out_of_range;
  logic [DATA_WIDTH-1:0] dead_pat;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem_q [NB_WORDS];

  logic [READ_LATENCY-1:0] pvalid_d, pvalid_q;
  logic [DATA_WIDTH-1:0]   pdata_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pdata_q [READ_LATENCY];

  logic [31:0] nb_reads_d, nb_reads_q;
  logic [31:0] nb_writes_d, nb_writes_q;
  logic        err_d, err_q;

  assign tcdm_gnt_o = tcdm_req_i & enable_i & ~stall_i & ~clear_i;
  assign accept     = tcdm_req_i & tcdm_gnt_o;
  assign rd_accept  = accept & tcdm_wen_i;
  assign wr_accept  = accept & ~tcdm_wen_i;

  // Any address bit above the word-index field marks the access as outside the bank.
  assign word_idx     = tcdm_add_i[OffW +: IdxW];
  assign add_hi       = tcdm_add_i >> HiLsb;
  assign out_of_range = |add_hi;

  assign dead_pat = {(DATA_WIDTH / 32){DeadWord}};
  assign rd_word  = out_of_range ? dead_pat : mem_q[word_idx];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_accept && !out_of_range) begin
      for (int b = 0; b < BeW; b++) begin
        if (tcdm_be_i[b]) mem_q[word_idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
      end
    end
  end

  // Data only advances alongside a surviving valid, so the output stage holds the last
  // returned word even when clear drops responses still in flight.
  always_comb begin
    pvalid_d    = '0;
    pvalid_d[0] = rd_accept;
    for (int i = 0; i < READ_LATENCY; i++) pdata_d[i] = pdata_q[i];
    if (rd_accept) pdata_d[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pvalid_d[i] = pvalid_q[i-1] & ~clear_i;
      if (pvalid_q[i-1] && !clear_i) pdata_d[i] = pdata_q[i-1];
    end
  end

  always_comb begin
    nb_reads_d  = nb_reads_q + {31'd0, rd_accept};
    nb_writes_d = nb_writes_q + {31'd0, wr_accept};
    err_d       = err_q | (accept & out_of_range);
    if (clear_i) begin
      nb_reads_d  = '0;
      nb_writes_d = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pvalid_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pdata_q[i] <= '0;
      nb_reads_q  <= '0;
      nb_writes_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pvalid_q    <= pvalid_d;
      for (int i = 0; i < READ_LATENCY; i++) pdata_q[i] <= pdata_d[i];
      nb_reads_q  <= nb_reads_d;
      nb_writes_q <= nb_writes_d;
      err_q       <= err_d;
    end
  end

  assign tcdm_r_valid_o = pvalid_q[READ_LATENCY-1];
  assign tcdm_r_data_o  = pdata_q[READ_LATENCY-1];
  assign nb_reads_o     = nb_reads_q;
  assign nb_writes_o    = nb_writes_q;
  assign err_o          = err_q;

endmodule
